bram_rd_streamer: RTL and testbench

//   Read-side master for the 18x512 dual-port coefficient BRAM: on start, issues sequential

---
 rtl/ntt_bram_pkg.sv | 13 +
 rtl/stream_fifo.sv | 64 ++++++
 rtl/bram_rd_streamer.sv | 119 +++++++++++
 tb/tb_bram_rd_streamer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ntt_bram_pkg.sv
// Shared definitions for the coefficient BRAM and the read streamer.
package ntt_bram_pkg;

   localparam int BRAM_DW = 18;
   localparam int BRAM_AW = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small first-word-fall-through FIFO; head is visible combinationally whenever cnt != 0.
module stream_fifo #(
   parameter int W     = 19,
   parameter int DEPTH = 3,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [CW-1:0] cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pop_ok;

   assign pop_ok = pop && (cnt_q != '0);
   assign head   = mem[rd_q];
   assign cnt    = cnt_q;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
         wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push, pop_ok})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_q] <= push_data;
      end
   end

endmodule

// File: rtl/bram_rd_streamer.sv
// Streams len sequential BRAM words from base_addr out as a valid/ready burst,
// hiding the one-cycle BRAM read latency behind a 3-deep output FIFO.
module bram_rd_streamer
   import ntt_bram_pkg::*;
#(
   parameter int DW     = BRAM_DW,
   parameter int AW     = BRAM_AW,
   parameter int FDEPTH = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_dout,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last
);

   localparam int CW = $clog2(FDEPTH + 1);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   remain_q, remain_d;
   logic          pend_q, pend_d;
   logic          pend_last_q, pend_last_d;
   logic          done_q, done_d;
   logic          issue, pop, fifo_valid;
   logic [CW-1:0] fifo_cnt;
   logic [DW:0]   head;

   stream_fifo #(.W(DW + 1), .DEPTH(FDEPTH), .CW(CW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (pend_q),
      .push_data ({pend_last_q, rd_dout}),
      .pop       (pop),
      .head      (head),
      .cnt       (fifo_cnt)
   );

   assign fifo_valid = (fifo_cnt != '0);
   assign m_valid    = fifo_valid;
   assign m_data     = fifo_valid ? head[DW-1:0] : '0;
   assign m_last     = fifo_valid & head[DW];
   assign pop        = fifo_valid & m_ready;
   assign rd_addr    = addr_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;

   // The in-flight read counts against FIFO space so its data always has a slot.
   assign issue = (state_q == ST_RUN) && (remain_q != '0) &&
                  ((int'(fifo_cnt) + int'(pend_q)) < FDEPTH);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remain_d    = remain_q;
      pend_d      = issue;
      pend_last_d = issue && (remain_q == (AW + 1)'(1));
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               remain_d = len;
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (issue) begin
               addr_d   = addr_q + AW'(1);
               remain_d = remain_q - (AW + 1)'(1);
            end
            if (pop && m_last) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if ((remain_q == '0) && !pend_q) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((pop && m_last) || !fifo_valid) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remain_q    <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remain_q    <= remain_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Directed and randomized bursts against a queue-based reference of the expected word stream.
module tb_bram_rd_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  base_addr;
   logic [9:0]  len;
   logic        busy;
   logic        done;
   logic [8:0]  rd_addr;
   logic [17:0] rd_dout;
   logic [17:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;

   int errors = 0;
   int checks = 0;

   logic [17:0] mem [512];
   logic [8:0]  lat_q;

   always #5 clk = ~clk;

   // BRAM read side: address latched every edge, data read from the latched address.
   always @(posedge clk) lat_q <= rd_addr;
   assign rd_dout = mem[lat_q];

   bram_rd_streamer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_dout   (rd_dout),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last)
   );

   function automatic logic [17:0] word_at(input int a);
      return 18'(a % 512) ^ 18'h2A5A5;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic burst(input int b, input int n, input bit rnd, input bit pester);
      logic [18:0] exp_q[$];
      logic [18:0] e;
      logic [17:0] prev_d;
      logic        prev_l;
      bit          prev_stall, fin;
      int          c, got, first_v, first_x, last_x;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({k == n - 1, word_at(b + k)});
      end
      base_addr = 9'(b);
      len       = 10'(n);
      start     = 1'b1;
      m_ready   = 1'b1;
      step();
      start = 1'b0;
      if (n == 0) begin
         chk("len0_done", done, 1);
         chk("len0_busy", busy, 0);
         chk("len0_valid", m_valid, 0);
         step();
         chk("len0_done_pulse", done, 0);
         chk("len0_valid_after", m_valid, 0);
         chk("len0_busy_after", busy, 0);
         $display("burst base=%0d len=0 done pulse observed", b);
         return;
      end
      chk("rd_addr_base", rd_addr, b);
      c = 0; got = 0; first_v = -1; first_x = -1; last_x = -1;
      prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0; fin = 1'b0;
      while (!fin && c < n + 400) begin
         if (done) begin
            fin   = 1'b1;
            start = 1'b0;
            chk("word_count", got, n);
            chk("done_latency", c, last_x + 1);
            chk("busy_at_done", busy, 0);
            chk("rd_addr_hold", rd_addr, (b + n) % 512);
         end else begin
            chk("busy_high", busy, 1);
            chk("fifo_cnt_le3", 32'(dut.fifo_cnt <= 3), 1);
            if (prev_stall) begin
               chk("stall_valid", m_valid, 1);
               chk("stall_data", m_data, prev_d);
               chk("stall_last", m_last, prev_l);
            end
            m_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = pester && (c % 37 == 5);
            base_addr = 9'(c);
            len       = 10'd3;
            if (m_valid && first_v < 0) begin
               first_v = c;
               chk("first_valid_latency", c, 2);
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_word", exp_q.size(), 1);
               end else begin
                  e = exp_q.pop_front();
                  chk("stream_word", {m_last, m_data}, e);
               end
               if (got == 0) first_x = c;
               got++;
               last_x = c;
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
            step();
            c++;
         end
      end
      start = 1'b0;
      if (!fin) chk("done_timeout", fin, 1);
      if (!rnd) chk("throughput", last_x - first_x, n - 1);
      step();
      chk("done_one_cycle", done, 0);
      $display("burst base=%0d len=%0d rnd=%0d words=%0d cycles=%0d", b, n, rnd, got, c);
   endtask

   initial begin
      int got, c;
      for (int i = 0; i < 512; i++) mem[i] = word_at(i);
      rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_data", m_data, 0);
      chk("rst_rd_addr", rd_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      $display("reset state checked");

      burst(0, 8, 1'b0, 1'b0);
      burst(510, 4, 1'b0, 1'b0);
      burst(16, 10, 1'b1, 1'b0);
      burst(33, 0, 1'b0, 1'b0);
      burst(0, 512, 1'b0, 1'b1);
      for (int r = 0; r < 3; r++) begin
         burst(int'($urandom_range(0, 511)), int'($urandom_range(1, 40)), 1'b1, 1'b0);
      end

      // Abort a burst with reset after five words.
      base_addr = 9'd200; len = 10'd20; start = 1'b1; m_ready = 1'b1;
      step();
      start = 1'b0;
      got = 0; c = 0;
      while (got < 5 && c < 50) begin
         if (m_valid && m_ready) got++;
         step();
         c++;
      end
      chk("abort_reached", got, 5);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_valid", m_valid, 0);
      chk("abort_done", done, 0);
      chk("abort_rd_addr", rd_addr, 0);
      $display("reset mid-burst after %0d words", got);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post_abort_valid", m_valid, 0);
      burst(100, 2, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
